// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register. It captures the decode-stage control bits,
//   instruction fields and operands, selects the write-destination register,
//   detects load-use hazards, and inserts bubbles on load-use stalls and on
//   downstream flush (branch/jump redirect). It also keeps a saturating count
//   of the bubbles inserted since reset.
//
// Parameters
//   DATA_W  width of register read data and sign-extended immediate
//   CNT_W   width of the bubble counter
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   *_d control bits         RegDest/ALUSrc/MemtoReg/RegWrite/MemRead/MemWrite
//   ALU_Control_d            ALU operation code (4'd15 = no-op)
//   rs_d, rt_d, rd_d, shamt_d  decode-stage instruction fields
//   rdata1_d, rdata2_d, imm_d  operands from decode
//   flush                    kills the instruction currently in decode
//   *_e outputs              registered execute-stage copies
//   wreg_e                   selected destination (rd when RegDest, else rt)
//   stall                    load-use hazard; holds PC and IF/ID upstream
//   bubble_cnt               bubbles inserted since reset, saturating
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              RegDest_d,
  input  logic              ALUSrc_d,
  input  logic              MemtoReg_d,
  input  logic              RegWrite_d,
  input  logic              MemRead_d,
  input  logic              MemWrite_d,
  input  logic [3:0]        ALU_Control_d,
  input  logic [4:0]        rs_d,
  input  logic [4:0]        rt_d,
  input  logic [4:0]        rd_d,
  input  logic [4:0]        shamt_d,
  input  logic [DATA_W-1:0] rdata1_d,
  input  logic [DATA_W-1:0] rdata2_d,
  input  logic [DATA_W-1:0] imm_d,
  input  logic              flush,

  output logic              RegDest_e,
  output logic              ALUSrc_e,
  output logic              MemtoReg_e,
  output logic              RegWrite_e,
  output logic              MemRead_e,
  output logic              MemWrite_e,
  output logic [3:0]        ALU_Control_e,
  output logic [4:0]        rs_e,
  output logic [4:0]        rt_e,
  output logic [4:0]        shamt_e,
  output logic [4:0]        wreg_e,
  output logic [DATA_W-1:0] rdata1_e,
  output logic [DATA_W-1:0] rdata2_e,
  output logic [DATA_W-1:0] imm_e,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [3:0] ALU_NOP = 4'd15;

  logic       load_bubble;
  logic [4:0] wreg_sel;
  logic       cnt_full;

  // Load-use hazard: the load in EX writes rt_e, which the decode instruction
  // reads. Register 0 is hard-wired and never creates a dependency. Only the
  // registered EX state and decode fields feed this; flush does not, so there
  // is no combinational flush->stall path. While rst is held MemRead_e is 0,
  // so stall reads 0 without an explicit reset term.
  assign stall = MemRead_e && (rt_e != 5'd0) && ((rt_e == rs_d) || (rt_e == rt_d));

  // Flush and stall together still insert a single bubble.
  assign load_bubble = flush || stall;

  assign wreg_sel = RegDest_d ? rd_d : rt_d;

  assign cnt_full = &bubble_cnt;

  // Control path: a bubble forces a harmless no-op into EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegDest_e     <= 1'b0;
      ALUSrc_e      <= 1'b0;
      MemtoReg_e    <= 1'b0;
      RegWrite_e    <= 1'b0;
      MemRead_e     <= 1'b0;
      MemWrite_e    <= 1'b0;
      ALU_Control_e <= ALU_NOP;
      wreg_e        <= 5'd0;
    end else if (load_bubble) begin
      RegDest_e     <= 1'b0;
      ALUSrc_e      <= 1'b0;
      MemtoReg_e    <= 1'b0;
      RegWrite_e    <= 1'b0;
      MemRead_e     <= 1'b0;
      MemWrite_e    <= 1'b0;
      ALU_Control_e <= ALU_NOP;
      wreg_e        <= 5'd0;
    end else begin
      RegDest_e     <= RegDest_d;
      ALUSrc_e      <= ALUSrc_d;
      MemtoReg_e    <= MemtoReg_d;
      RegWrite_e    <= RegWrite_d;
      MemRead_e     <= MemRead_d;
      MemWrite_e    <= MemWrite_d;
      ALU_Control_e <= ALU_Control_d;
      wreg_e        <= wreg_sel;
    end
  end

  // Data path: fields and operands are captured unconditionally. During a
  // bubble they are don't-care because every side-effecting control bit is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_e     <= 5'd0;
      rt_e     <= 5'd0;
      shamt_e  <= 5'd0;
      rdata1_e <= '0;
      rdata2_e <= '0;
      imm_e    <= '0;
    end else begin
      rs_e     <= rs_d;
      rt_e     <= rt_d;
      shamt_e  <= shamt_d;
      rdata1_e <= rdata1_d;
      rdata2_e <= rdata2_d;
      imm_e    <= imm_d;
    end
  end

  // Saturating bubble counter; holds at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (load_bubble && !cnt_full) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic        regdest, alusrc, memtoreg, regwrite, memread, memwrite;
    logic [3:0]  alu;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] r1, r2, imm;
  } dec_t;

  typedef struct {
    logic        regdest, alusrc, memtoreg, regwrite, memread, memwrite;
    logic [3:0]  alu;
    logic [4:0]  rs, rt, shamt, wreg;
    logic [31:0] r1, r2, imm;
  } ex_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  dec_t dec;

  logic RegDest_e, ALUSrc_e, MemtoReg_e, RegWrite_e, MemRead_e, MemWrite_e;
  logic [3:0]    ALU_Control_e;
  logic [4:0]    rs_e, rt_e, shamt_e, wreg_e;
  logic [DW-1:0] rdata1_e, rdata2_e, imm_e;
  logic          stall;
  logic [CW-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .RegDest_d(dec.regdest), .ALUSrc_d(dec.alusrc), .MemtoReg_d(dec.memtoreg),
    .RegWrite_d(dec.regwrite), .MemRead_d(dec.memread), .MemWrite_d(dec.memwrite),
    .ALU_Control_d(dec.alu), .rs_d(dec.rs), .rt_d(dec.rt), .rd_d(dec.rd),
    .shamt_d(dec.shamt), .rdata1_d(dec.r1), .rdata2_d(dec.r2), .imm_d(dec.imm),
    .flush(flush),
    .RegDest_e(RegDest_e), .ALUSrc_e(ALUSrc_e), .MemtoReg_e(MemtoReg_e),
    .RegWrite_e(RegWrite_e), .MemRead_e(MemRead_e), .MemWrite_e(MemWrite_e),
    .ALU_Control_e(ALU_Control_e), .rs_e(rs_e), .rt_e(rt_e), .shamt_e(shamt_e),
    .wreg_e(wreg_e), .rdata1_e(rdata1_e), .rdata2_e(rdata2_e), .imm_e(imm_e),
    .stall(stall), .bubble_cnt(bubble_cnt)
  );

  // ---------------- instruction builders ----------------
  function automatic dec_t i_nop();
    dec_t d;
    d = '{default: '0};
    d.alu = 4'd15;
    return d;
  endfunction

  function automatic dec_t i_add(input logic [4:0] rs, rt, rd);
    dec_t d;
    d = '{default: '0};
    d.regdest = 1'b1; d.regwrite = 1'b1; d.alu = 4'd2;
    d.rs = rs; d.rt = rt; d.rd = rd; d.shamt = 5'd1;
    d.r1 = 32'h1000 + 32'(rs); d.r2 = 32'h2000 + 32'(rt); d.imm = 32'hFFFF_FFF0;
    return d;
  endfunction

  function automatic dec_t i_lw(input logic [4:0] rs, rt, input logic [31:0] imm);
    dec_t d;
    d = '{default: '0};
    d.alusrc = 1'b1; d.memtoreg = 1'b1; d.regwrite = 1'b1; d.memread = 1'b1;
    d.alu = 4'd2; d.rs = rs; d.rt = rt; d.rd = 5'd31;
    d.r1 = 32'hA000_0000; d.r2 = 32'h5A5A_5A5A; d.imm = imm;
    return d;
  endfunction

  function automatic dec_t i_sw(input logic [4:0] rs, rt, input logic [31:0] imm);
    dec_t d;
    d = '{default: '0};
    d.alusrc = 1'b1; d.memwrite = 1'b1; d.alu = 4'd2;
    d.rs = rs; d.rt = rt; d.rd = 5'd4;
    d.r1 = 32'hB000_0000; d.r2 = 32'hDEAD_BEEF; d.imm = imm;
    return d;
  endfunction

  // ---------------- behavioural model ----------------
  // Expected EX contents: either the decoded instruction (with its chosen
  // destination) or a no-op whenever it is killed by flush or a load-use hazard.
  ex_t m;
  int  m_cnt;

  function automatic ex_t ex_reset();
    ex_t e;
    e = '{default: '0};
    e.alu = 4'd15;
    return e;
  endfunction

  function automatic bit model_hazard();
    return m.memread && (m.rt != 0) && (m.rt == dec.rs || m.rt == dec.rt);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m = ex_reset();
      m_cnt = 0;
    end else begin
      ex_t nx;
      bit  kill;
      kill = flush || model_hazard();
      nx.rs = dec.rs; nx.rt = dec.rt; nx.shamt = dec.shamt;
      nx.r1 = dec.r1; nx.r2 = dec.r2; nx.imm = dec.imm;
      if (kill) begin
        nx.regdest = 0; nx.alusrc = 0; nx.memtoreg = 0; nx.regwrite = 0;
        nx.memread = 0; nx.memwrite = 0; nx.alu = 4'd15; nx.wreg = 0;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end else begin
        nx.regdest = dec.regdest; nx.alusrc = dec.alusrc; nx.memtoreg = dec.memtoreg;
        nx.regwrite = dec.regwrite; nx.memread = dec.memread; nx.memwrite = dec.memwrite;
        nx.alu = dec.alu;
        nx.wreg = dec.regdest ? dec.rd : dec.rt;
      end
      m = nx;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("RegDest_e",  64'(RegDest_e),  64'(m.regdest));
    chk("ALUSrc_e",   64'(ALUSrc_e),   64'(m.alusrc));
    chk("MemtoReg_e", 64'(MemtoReg_e), 64'(m.memtoreg));
    chk("RegWrite_e", 64'(RegWrite_e), 64'(m.regwrite));
    chk("MemRead_e",  64'(MemRead_e),  64'(m.memread));
    chk("MemWrite_e", 64'(MemWrite_e), 64'(m.memwrite));
    chk("ALU_Control_e", 64'(ALU_Control_e), 64'(m.alu));
    chk("rs_e",    64'(rs_e),    64'(m.rs));
    chk("rt_e",    64'(rt_e),    64'(m.rt));
    chk("shamt_e", 64'(shamt_e), 64'(m.shamt));
    chk("wreg_e",  64'(wreg_e),  64'(m.wreg));
    chk("rdata1_e", 64'(rdata1_e), 64'(m.r1));
    chk("rdata2_e", 64'(rdata2_e), 64'(m.r2));
    chk("imm_e",    64'(imm_e),    64'(m.imm));
    chk("stall",      64'(stall),      64'(model_hazard()));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    dec   = i_lw(5'd1, 5'd8, 32'd4);
    step();
    chk("rst ALU", 64'(ALU_Control_e), 64'd15);
    chk("rst RegWrite", 64'(RegWrite_e), 64'd0);
    chk("rst cnt", 64'(bubble_cnt), 64'd0);
    chk("rst stall", 64'(stall), 64'd0);

    rst = 1'b0;
    dec = i_nop();
    step();

    // ADD r5 = r1 + r3
    dec = i_add(5'd1, 5'd3, 5'd5);
    #1 chk("add stall", 64'(stall), 64'd0);
    step();
    chk("add RegWrite", 64'(RegWrite_e), 64'd1);
    chk("add ALU", 64'(ALU_Control_e), 64'd2);
    chk("add wreg", 64'(wreg_e), 64'd5);

    // LW r8, then dependent ADD reading r8 through rs
    dec = i_lw(5'd2, 5'd8, 32'd16);
    step();
    chk("lw wreg", 64'(wreg_e), 64'd8);
    chk("lw MemRead", 64'(MemRead_e), 64'd1);
    dec = i_add(5'd8, 5'd3, 5'd6);
    #1 chk("lu stall", 64'(stall), 64'd1);
    step();
    chk("bub RegWrite", 64'(RegWrite_e), 64'd0);
    chk("bub ALU", 64'(ALU_Control_e), 64'd15);
    chk("bub cnt", 64'(bubble_cnt), 64'd1);
    chk("bub stall clr", 64'(stall), 64'd0);
    step();
    chk("after bub wreg", 64'(wreg_e), 64'd6);
    chk("after bub cnt", 64'(bubble_cnt), 64'd1);

    // LW r0 followed by reader of r0: no hazard
    dec = i_lw(5'd2, 5'd0, 32'd8);
    step();
    dec = i_add(5'd0, 5'd0, 5'd7);
    #1 chk("r0 stall", 64'(stall), 64'd0);
    step();
    chk("r0 RegWrite", 64'(RegWrite_e), 64'd1);
    chk("r0 cnt", 64'(bubble_cnt), 64'd1);

    // Hazard via rt_d
    dec = i_lw(5'd3, 5'd9, 32'd0);
    step();
    dec = i_add(5'd2, 5'd9, 5'd10);
    #1 chk("rt stall", 64'(stall), 64'd1);
    step();
    chk("rt cnt", 64'(bubble_cnt), 64'd2);

    // Flush kills a store
    dec = i_sw(5'd4, 5'd5, 32'd12);
    flush = 1'b1;
    step();
    chk("flush MemWrite", 64'(MemWrite_e), 64'd0);
    chk("flush ALU", 64'(ALU_Control_e), 64'd15);
    chk("flush cnt", 64'(bubble_cnt), 64'd3);

    // Flush and stall together count once
    flush = 1'b0;
    dec = i_lw(5'd1, 5'd7, 32'd20);
    step();
    dec = i_add(5'd7, 5'd2, 5'd11);
    flush = 1'b1;
    #1 chk("fs stall", 64'(stall), 64'd1);
    step();
    chk("fs cnt", 64'(bubble_cnt), 64'd4);

    // Saturation
    dec = i_sw(5'd4, 5'd5, 32'd12);
    for (int i = 0; i < 20; i++) step();
    chk("sat cnt", 64'(bubble_cnt), 64'(CNT_MAX));
    step();
    chk("sat hold", 64'(bubble_cnt), 64'(CNT_MAX));

    // Mid-cycle reset
    flush = 1'b0;
    dec = i_add(5'd1, 5'd2, 5'd12);
    step();
    chk("pre rst RegWrite", 64'(RegWrite_e), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid rst RegWrite", 64'(RegWrite_e), 64'd0);
    chk("mid rst ALU", 64'(ALU_Control_e), 64'd15);
    chk("mid rst cnt", 64'(bubble_cnt), 64'd0);
    chk("mid rst wreg", 64'(wreg_e), 64'd0);
    dec = i_lw(5'd1, 5'd0, 32'd0);
    step();
    dec = i_add(5'd0, 5'd0, 5'd1);
    #1 chk("rst stall", 64'(stall), 64'd0);
    step();
    rst = 1'b0;
    dec = i_add(5'd1, 5'd2, 5'd13);
    step();
    chk("post rst RegWrite", 64'(RegWrite_e), 64'd1);
    chk("post rst wreg", 64'(wreg_e), 64'd13);
    chk("post rst cnt", 64'(bubble_cnt), 64'd0);

    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
